// File: rtl/score_keeper.sv
// Gameplay scoring engine: tracks streak, combo multiplier and a saturating
// 20-bit score across the song lifecycle (idle / playing / paused / done).
module score_keeper #(
  parameter int unsigned PTS_GOOD    = 50,
  parameter int unsigned PTS_GREAT   = 100,
  parameter int unsigned PTS_PERFECT = 200,
  parameter int unsigned SCORE_MAX   = 999999
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        song_start,
  input  logic        song_end,
  input  logic        pause,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  input  logic        note_miss,
  output logic [19:0] score_bin,
  output logic [9:0]  streak,
  output logic [9:0]  max_streak,
  output logic [2:0]  multiplier,
  output logic        score_updated,
  output logic        playing
);

  typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, DONE} state_t;

  state_t      state, state_next;
  logic [19:0] score_next;
  logic [9:0]  streak_next, max_next;
  logic [2:0]  mult_next;
  logic        miss, hit, active;
  logic [7:0]  base;
  logic [9:0]  product;
  logic [20:0] sum;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (song_start) state_next = PLAYING;
      PLAYING: begin
        if (song_start)    state_next = PLAYING;
        else if (song_end) state_next = DONE;
        else if (pause)    state_next = PAUSED;
      end
      PAUSED: begin
        if (song_start)    state_next = PLAYING;
        else if (song_end) state_next = DONE;
        else if (!pause)   state_next = PLAYING;
      end
      DONE:    if (song_start) state_next = PLAYING;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    miss   = note_miss | (hit_valid & (hit_grade == 2'd0));
    hit    = hit_valid & (hit_grade != 2'd0) & ~miss;
    // Events only count in a settled PLAYING cycle; a rising pause or a
    // lifecycle pulse in the same cycle swallows them.
    active = (state == PLAYING) & ~pause & ~song_start & ~song_end;

    case (hit_grade)
      2'd1:    base = 8'(PTS_GOOD);
      2'd2:    base = 8'(PTS_GREAT);
      2'd3:    base = 8'(PTS_PERFECT);
      default: base = '0;
    endcase
    product = {2'b00, base} * {7'b0, multiplier};
    sum     = {1'b0, score_bin} + {11'b0, product};

    score_next  = score_bin;
    streak_next = streak;
    max_next    = max_streak;
    if (song_start) begin
      score_next  = '0;
      streak_next = '0;
      max_next    = '0;
    end else if (active) begin
      if (miss) begin
        streak_next = '0;
      end else if (hit) begin
        score_next  = (sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : sum[19:0];
        streak_next = (streak == '1) ? streak : streak + 10'd1;
        if (streak_next > max_streak) max_next = streak_next;
      end
    end

    if (streak_next >= 10'd30)      mult_next = 3'd4;
    else if (streak_next >= 10'd20) mult_next = 3'd3;
    else if (streak_next >= 10'd10) mult_next = 3'd2;
    else                            mult_next = 3'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      score_bin     <= '0;
      streak        <= '0;
      max_streak    <= '0;
      multiplier    <= 3'd1;
      score_updated <= 1'b0;
    end else begin
      state         <= state_next;
      score_bin     <= score_next;
      streak        <= streak_next;
      max_streak    <= max_next;
      multiplier    <= mult_next;
      score_updated <= (score_next != score_bin);
    end
  end

  assign playing = (state == PLAYING);

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with hand-computed expectations.
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        reset_n, song_start, song_end, pause, hit_valid, note_miss;
  logic [1:0]  hit_grade;
  logic [19:0] score_bin;
  logic [9:0]  streak, max_streak;
  logic [2:0]  multiplier;
  logic        score_updated, playing;

  int checks = 0;
  int failures = 0;

  score_keeper #(
    .PTS_GOOD(50), .PTS_GREAT(100), .PTS_PERFECT(200), .SCORE_MAX(999999)
  ) dut (
    .clock(clock), .reset_n(reset_n), .song_start(song_start),
    .song_end(song_end), .pause(pause), .hit_valid(hit_valid),
    .hit_grade(hit_grade), .note_miss(note_miss), .score_bin(score_bin),
    .streak(streak), .max_streak(max_streak), .multiplier(multiplier),
    .score_updated(score_updated), .playing(playing)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic hit(input logic [1:0] g);
    hit_valid = 1'b1; hit_grade = g;
    step();
    hit_valid = 1'b0; hit_grade = 2'd0;
  endtask

  task automatic start();
    song_start = 1'b1;
    step();
    song_start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    checks++; if (score_bin !== 20'd0) begin $display("FAIL reset_score got=%0d exp=0", score_bin); failures++; end
    checks++; if (streak !== 10'd0) begin $display("FAIL reset_streak got=%0d exp=0", streak); failures++; end
    checks++; if (max_streak !== 10'd0) begin $display("FAIL reset_max got=%0d exp=0", max_streak); failures++; end
    checks++; if (multiplier !== 3'd1) begin $display("FAIL reset_mult got=%0d exp=1", multiplier); failures++; end
    checks++; if (score_updated !== 1'b0) begin $display("FAIL reset_upd got=%b exp=0", score_updated); failures++; end
    checks++; if (playing !== 1'b0) begin $display("FAIL reset_playing got=%b exp=0", playing); failures++; end
  endtask

  task automatic test_basic();
    start();
    checks++; if (playing !== 1'b1) begin $display("FAIL basic_playing got=%b exp=1", playing); failures++; end
    checks++; if (score_updated !== 1'b0) begin $display("FAIL basic_clear_from_zero_upd got=%b exp=0", score_updated); failures++; end
    for (int i = 0; i < 3; i++) begin
      hit(2'd3);
      checks++; if (score_updated !== 1'b1) begin $display("FAIL basic_upd_%0d got=%b exp=1", i, score_updated); failures++; end
      checks++; if (score_bin !== 20'(200 * (i + 1))) begin $display("FAIL basic_step_%0d got=%0d exp=%0d", i, score_bin, 200 * (i + 1)); failures++; end
    end
    step();
    checks++; if (score_updated !== 1'b0) begin $display("FAIL basic_upd_idle got=%b exp=0", score_updated); failures++; end
    checks++; if (score_bin !== 20'd600) begin $display("FAIL basic_score got=%0d exp=600", score_bin); failures++; end
    checks++; if (streak !== 10'd3) begin $display("FAIL basic_streak got=%0d exp=3", streak); failures++; end
    checks++; if (multiplier !== 3'd1) begin $display("FAIL basic_mult got=%0d exp=1", multiplier); failures++; end
  endtask

  task automatic test_multiplier();
    start();
    checks++; if (score_updated !== 1'b1 || score_bin !== 20'd0) begin $display("FAIL mult_restart got=%0d/%b exp=0/1", score_bin, score_updated); failures++; end
    for (int i = 0; i < 9; i++) hit(2'd1);
    checks++; if (score_bin !== 20'd450 || multiplier !== 3'd1) begin $display("FAIL mult_9good got=%0d x%0d exp=450 x1", score_bin, multiplier); failures++; end
    hit(2'd3);
    checks++; if (score_bin !== 20'd650) begin $display("FAIL mult_10th_score got=%0d exp=650", score_bin); failures++; end
    checks++; if (multiplier !== 3'd2 || streak !== 10'd10) begin $display("FAIL mult_10th_mult got=x%0d s%0d exp=x2 s10", multiplier, streak); failures++; end
    hit(2'd1);
    checks++; if (score_bin !== 20'd750) begin $display("FAIL mult_11th_score got=%0d exp=750", score_bin); failures++; end
  endtask

  task automatic test_miss();
    start();
    for (int i = 0; i < 25; i++) hit(2'd1);
    checks++; if (score_bin !== 20'd2250 || streak !== 10'd25 || multiplier !== 3'd3) begin $display("FAIL miss_pre got=%0d s%0d x%0d exp=2250 s25 x3", score_bin, streak, multiplier); failures++; end
    note_miss = 1'b1; hit_valid = 1'b1; hit_grade = 2'd2;
    step();
    note_miss = 1'b0; hit_valid = 1'b0; hit_grade = 2'd0;
    checks++; if (streak !== 10'd0) begin $display("FAIL miss_streak got=%0d exp=0", streak); failures++; end
    checks++; if (score_bin !== 20'd2250 || score_updated !== 1'b0) begin $display("FAIL miss_score got=%0d/%b exp=2250/0", score_bin, score_updated); failures++; end
    checks++; if (multiplier !== 3'd1) begin $display("FAIL miss_mult got=%0d exp=1", multiplier); failures++; end
    checks++; if (max_streak !== 10'd25) begin $display("FAIL miss_max got=%0d exp=25", max_streak); failures++; end
    hit(2'd1);
    hit(2'd0);
    checks++; if (streak !== 10'd0 || score_bin !== 20'd2300 || max_streak !== 10'd25) begin $display("FAIL miss_grade0 got=s%0d %0d m%0d exp=s0 2300 m25", streak, score_bin, max_streak); failures++; end
  endtask

  task automatic test_saturation();
    start();
    for (int i = 0; i < 9; i++) hit(2'd3);
    hit(2'd2);
    for (int i = 0; i < 20; i++) hit(2'd3);
    checks++; if (score_bin !== 20'd11900 || multiplier !== 3'd4) begin $display("FAIL sat_mid got=%0d x%0d exp=11900 x4", score_bin, multiplier); failures++; end
    for (int i = 0; i < 1234; i++) hit(2'd3);
    hit(2'd2);
    checks++; if (score_bin !== 20'd999500) begin $display("FAIL sat_preload got=%0d exp=999500", score_bin); failures++; end
    checks++; if (streak !== 10'd1023 || max_streak !== 10'd1023) begin $display("FAIL sat_streak got=%0d/%0d exp=1023/1023", streak, max_streak); failures++; end
    hit(2'd3);
    checks++; if (score_bin !== 20'd999999 || score_updated !== 1'b1) begin $display("FAIL sat_clip got=%0d/%b exp=999999/1", score_bin, score_updated); failures++; end
    hit(2'd1);
    checks++; if (score_bin !== 20'd999999 || score_updated !== 1'b0) begin $display("FAIL sat_hold got=%0d/%b exp=999999/0", score_bin, score_updated); failures++; end
  endtask

  task automatic test_pause();
    start();
    hit(2'd1); hit(2'd1);
    pause = 1'b1;
    hit(2'd3);
    checks++; if (score_bin !== 20'd100 || playing !== 1'b0) begin $display("FAIL pause_rise got=%0d/%b exp=100/0", score_bin, playing); failures++; end
    for (int i = 0; i < 5; i++) hit(2'd3);
    checks++; if (score_bin !== 20'd100 || streak !== 10'd2) begin $display("FAIL pause_hits got=%0d s%0d exp=100 s2", score_bin, streak); failures++; end
    song_end = 1'b1; step(); song_end = 1'b0;
    pause = 1'b0;
    for (int i = 0; i < 5; i++) hit(2'd3);
    checks++; if (score_bin !== 20'd100 || playing !== 1'b0) begin $display("FAIL done_hits got=%0d/%b exp=100/0", score_bin, playing); failures++; end
    start();
    checks++; if (score_bin !== 20'd0 || playing !== 1'b1 || score_updated !== 1'b1) begin $display("FAIL done_restart got=%0d/%b/%b exp=0/1/1", score_bin, playing, score_updated); failures++; end
    pause = 1'b1; step();
    pause = 1'b0; hit(2'd1);
    checks++; if (score_bin !== 20'd0 || playing !== 1'b1) begin $display("FAIL resume_drop got=%0d/%b exp=0/1", score_bin, playing); failures++; end
    hit(2'd1);
    checks++; if (score_bin !== 20'd50 || streak !== 10'd1) begin $display("FAIL resume_hit got=%0d s%0d exp=50 s1", score_bin, streak); failures++; end
  endtask

  task automatic test_back_to_back();
    song_start = 1'b1; song_end = 1'b1; hit_valid = 1'b1; hit_grade = 2'd3;
    step();
    song_start = 1'b0; song_end = 1'b0; hit_valid = 1'b0; hit_grade = 2'd0;
    checks++; if (score_bin !== 20'd0 || playing !== 1'b1 || streak !== 10'd0) begin $display("FAIL prio_start got=%0d/%b s%0d exp=0/1 s0", score_bin, playing, streak); failures++; end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) hit(2'd1);
    checks++; if (score_bin !== 20'd250) begin $display("FAIL rmid_pre got=%0d exp=250", score_bin); failures++; end
    reset_n = 1'b0; step(); reset_n = 1'b1;
    checks++; if (score_bin !== 20'd0 || streak !== 10'd0 || max_streak !== 10'd0 || multiplier !== 3'd1 || score_updated !== 1'b0 || playing !== 1'b0)
      begin $display("FAIL rmid_reset got=%0d s%0d m%0d x%0d u%b p%b exp=0 s0 m0 x1 u0 p0", score_bin, streak, max_streak, multiplier, score_updated, playing); failures++; end
    for (int i = 0; i < 3; i++) hit(2'd3);
    checks++; if (score_bin !== 20'd0 || streak !== 10'd0) begin $display("FAIL rmid_ignored got=%0d s%0d exp=0 s0", score_bin, streak); failures++; end
    start();
    hit(2'd3);
    checks++; if (score_bin !== 20'd200 || streak !== 10'd1) begin $display("FAIL rmid_resume got=%0d s%0d exp=200 s1", score_bin, streak); failures++; end
  endtask

  initial begin
    reset_n = 1'b0; song_start = 1'b0; song_end = 1'b0; pause = 1'b0;
    hit_valid = 1'b0; hit_grade = 2'd0; note_miss = 1'b0;
    test_reset();
    test_basic();
    test_multiplier();
    test_miss();
    test_saturation();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
